// File: rtl/uart_arb_defs.sv
// Shared definitions for the UART TX arbiter: FSM state codes and the
// grant-index width helper.
package uart_arb_defs;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // A single requester still gets a 1-bit index so port widths never collapse to zero.
  function automatic int gw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after
// last_grant, wrapping modulo N_REQ.
module rr_pick
  import uart_arb_defs::*;
#(
  parameter int N_REQ = 2,
  parameter int GW    = gw_of(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    idx,
  output logic             any
);

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % N_REQ]) begin
        idx = GW'((int'(last_grant) + k) % N_REQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one UART TX byte channel between
// N_REQ sources, with a stall watchdog that forces release of a silent grantee.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no grant; pick the next requester, lock on the next edge
//   ST_LOCKED | grantee's valid/data/last pass straight through to tx_*
module uart_tx_arbiter
  import uart_arb_defs::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int TIMEOUT = 1_200_000,
  localparam int GW      = gw_of(N_REQ)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [GW-1:0]      grant_idx,
  output logic               busy,
  output logic               abort
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [0:0]    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic [WW-1:0] wd_cnt;
  logic          locked;
  logic          g_valid;
  logic          g_last;
  logic          beat_last;
  logic          stall;
  logic          wd_expire;

  rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // Reset gates the pass-through so nothing leaks to the transmitter while RST is high.
  assign locked    = (state == ST_LOCKED) && !RST;
  assign g_valid   = req_valid[grant_idx];
  assign g_last    = req_last[grant_idx];
  assign tx_valid  = locked && g_valid;
  assign tx_data   = req_data[{grant_idx, 3'b000} +: 8];
  assign beat_last = tx_valid && tx_ready && g_last;
  assign stall     = locked && !g_valid;
  assign wd_expire = (TIMEOUT > 0) && stall && (wd_cnt == WW'(TIMEOUT - 1));
  assign abort     = wd_expire;
  assign busy      = (state == ST_LOCKED);

  always_comb begin
    req_ready = '0;
    if (locked) req_ready[grant_idx] = tx_ready;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      last_grant <= GW'(N_REQ - 1);
      wd_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (pick_any) begin
            grant_idx <= pick_idx;
            state     <= ST_LOCKED;
          end
        end
        default: begin
          if (beat_last || wd_expire) begin
            state      <= ST_IDLE;
            last_grant <= grant_idx;
            wd_cnt     <= '0;
          end else if (g_valid) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
      endcase
    end
  end

  // A final beat needs the grantee's valid high, which also clears the watchdog.
  a_no_last_and_abort: assert property (@(posedge CLK) disable iff (RST)
    !(wd_expire && beat_last));

endmodule
